// File: rtl/dma_controller.sv
// DMA engine: latches the device interrupt for the CPU, then on command arbitrates
// for the bus and copies NUM_BLOCKS device blocks to consecutive memory addresses.
module dma_controller #(
  parameter int WORD_SIZE   = 16,
  parameter int BLOCK_WORDS = 4,
  parameter int NUM_BLOCKS  = 3
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             dev_interrupt,
  output logic [1:0]                       dev_offset,
  input  logic [BLOCK_WORDS*WORD_SIZE-1:0] dev_data,
  output logic                             cpu_irq,
  input  logic                             cmd_valid,
  input  logic [WORD_SIZE-1:0]             cmd_addr,
  output logic                             br,
  input  logic                             bg,
  output logic                             mem_write,
  output logic [WORD_SIZE-1:0]             mem_addr,
  output logic [BLOCK_WORDS*WORD_SIZE-1:0] mem_data,
  input  logic                             mem_ready,
  output logic                             busy,
  output logic                             done
);

  localparam logic [1:0] LAST_BLK = 2'(NUM_BLOCKS - 1);

  typedef enum logic [2:0] {IDLE, REQ, FETCH, WRITE, DONE} state_t;

  state_t               state, state_nxt;
  logic [1:0]           blk, blk_nxt;
  logic [WORD_SIZE-1:0] base;
  logic                 irq_prev;
  logic [WORD_SIZE-1:0] blk_addr;
  logic                 accept;

  assign accept   = (state == IDLE) && cmd_valid;
  assign busy     = (state != IDLE);
  // Wraps modulo 2^WORD_SIZE by construction of the sum width.
  assign blk_addr = base + WORD_SIZE'(blk) * WORD_SIZE'(BLOCK_WORDS);

  always_comb begin
    state_nxt = state;
    blk_nxt   = blk;
    unique case (state)
      IDLE: begin
        if (cmd_valid) begin
          blk_nxt   = '0;
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (bg) state_nxt = FETCH;
      end
      FETCH: begin
        state_nxt = bg ? WRITE : REQ;
      end
      WRITE: begin
        // Losing the grant takes priority over a simultaneous mem_ready.
        if (!bg) begin
          state_nxt = REQ;
        end else if (mem_ready) begin
          if (blk == LAST_BLK) begin
            state_nxt = DONE;
          end else begin
            blk_nxt   = blk + 2'd1;
            state_nxt = FETCH;
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      blk   <= '0;
    end else begin
      state <= state_nxt;
      blk   <= blk_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) base <= cmd_addr;
  end

  // Registered outputs are decoded from the next state so they align with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_prev   <= dev_interrupt;
      cpu_irq    <= 1'b0;
      br         <= 1'b0;
      mem_write  <= 1'b0;
      done       <= 1'b0;
      dev_offset <= '0;
      mem_addr   <= '0;
      mem_data   <= '0;
    end else begin
      irq_prev <= dev_interrupt;
      if (dev_interrupt && !irq_prev) begin
        cpu_irq <= 1'b1;
      end else if (accept) begin
        cpu_irq <= 1'b0;
      end
      br        <= (state_nxt == REQ) || (state_nxt == FETCH) || (state_nxt == WRITE);
      mem_write <= (state_nxt == WRITE);
      done      <= (state_nxt == DONE);
      if (state_nxt == FETCH) dev_offset <= blk_nxt;
      if ((state == FETCH) && (state_nxt == WRITE)) begin
        mem_data <= dev_data;
        mem_addr <= blk_addr;
      end
    end
  end

endmodule

// File: tb/tb_dma_controller.sv
// Bench for dma_controller: directed scenarios plus randomized bus/memory handshakes,
// with expected writes and done timing derived from the transfer rules.
module tb_dma_controller;

  localparam int WS = 16;
  localparam int BW = 4;
  localparam int NB = 3;
  localparam int DW = WS * BW;

  logic          clk = 1'b0;
  logic          reset, dev_interrupt, cmd_valid, bg, mem_ready;
  logic [WS-1:0] cmd_addr;
  logic [1:0]    dev_offset;
  logic [DW-1:0] dev_data;
  logic          cpu_irq, br, mem_write, busy, done;
  logic [WS-1:0] mem_addr;
  logic [DW-1:0] mem_data;

  logic [DW-1:0]    dev_mem [NB];
  logic [WS+DW-1:0] wr_q [$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int offset_bad = 0;

  dma_controller #(.WORD_SIZE(WS), .BLOCK_WORDS(BW), .NUM_BLOCKS(NB)) dut (
    .clk(clk), .reset(reset), .dev_interrupt(dev_interrupt), .dev_offset(dev_offset),
    .dev_data(dev_data), .cpu_irq(cpu_irq), .cmd_valid(cmd_valid), .cmd_addr(cmd_addr),
    .br(br), .bg(bg), .mem_write(mem_write), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_ready(mem_ready), .busy(busy), .done(done)
  );

  assign dev_data = (int'(dev_offset) < NB) ? dev_mem[dev_offset] : '0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Observe mid-cycle: a write completes at the coming edge when strobe, ready and grant coincide.
  always @(negedge clk) begin
    if (!reset && mem_write && mem_ready && bg) wr_q.push_back({mem_addr, mem_data});
    if (done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
    if (int'(dev_offset) >= NB) offset_bad = offset_bad + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [WS-1:0] a);
    cmd_addr  = a;
    cmd_valid = 1'b1;
    wr_q.delete();
    done_cnt  = 0;
    tick();
    cmd_valid = 1'b0;
    acc_cyc   = cyc;
  endtask

  task automatic wait_done(input int lim, input string tag);
    int n;
    n = 0;
    while (done_cnt == 0 && n < lim) begin
      tick();
      n++;
    end
    chk({tag, " done seen"}, 128'(done_cnt != 0), 128'(1));
  endtask

  task automatic check_writes(input logic [WS-1:0] b, input string tag);
    logic [WS-1:0] a;
    chk({tag, " write count"}, 128'(wr_q.size()), 128'(NB));
    for (int i = 0; i < NB; i++) begin
      a = b + WS'(i * BW);
      if (i < wr_q.size()) chk($sformatf("%s blk%0d", tag, i), 128'(wr_q[i]), 128'({a, dev_mem[i]}));
    end
  endtask

  function automatic logic [DW-1:0] rnd_block();
    return {$urandom, $urandom};
  endfunction

  initial begin
    logic [WS-1:0] b;
    logic [3:0]    ctl;

    reset = 1'b1; dev_interrupt = 1'b0; cmd_valid = 1'b0; bg = 1'b0; mem_ready = 1'b0;
    cmd_addr = '0;
    for (int i = 0; i < NB; i++) dev_mem[i] = '0;
    tick();
    tick();
    chk("reset outputs", 128'({dev_offset, cpu_irq, br, mem_write, mem_addr, mem_data, busy, done}), 128'(0));
    reset = 1'b0;
    tick();

    // Interrupt latch: rising edge sets, held level does not re-trigger.
    dev_interrupt = 1'b1;
    chk("irq before edge", 128'(cpu_irq), 128'(0));
    tick();
    chk("irq set", 128'(cpu_irq), 128'(1));
    repeat (9) tick();
    chk("irq held", 128'(cpu_irq), 128'(1));

    // Basic transfer, level still high: accept clears irq, no re-trigger.
    dev_mem[0] = 64'h1111_2222_3333_4444;
    dev_mem[1] = 64'hAAAA_BBBB_CCCC_DDDD;
    dev_mem[2] = 64'h0123_4567_89AB_CDEF;
    bg = 1'b1; mem_ready = 1'b1;
    start(16'h0100);
    chk("irq cleared by accept", 128'(cpu_irq), 128'(0));
    for (int n = 1; n <= 9; n++) begin
      ctl = {n <= 7, (n == 3) || (n == 5) || (n == 7), n == 8, n <= 8};
      chk($sformatf("basic cycle%0d br/wr/done/busy", n), 128'({br, mem_write, done, busy}), 128'(ctl));
      if (n == 2 || n == 4 || n == 6) chk($sformatf("basic cycle%0d offset", n), 128'(dev_offset), 128'((n - 2) / 2));
      tick();
    end
    chk("basic done count", 128'(done_cnt), 128'(1));
    chk("basic done cycle", 128'(done_cyc - acc_cyc), 128'(7));
    check_writes(16'h0100, "basic");
    chk("irq no retrigger", 128'(cpu_irq), 128'(0));
    dev_interrupt = 1'b0;
    tick();

    // Address wrap; interrupt edge coincides with accept and must win.
    for (int i = 0; i < NB; i++) dev_mem[i] = rnd_block();
    dev_interrupt = 1'b1;
    start(16'hFFFC);
    chk("irq set wins over accept", 128'(cpu_irq), 128'(1));
    wait_done(50, "wrap");
    chk("wrap done cycle", 128'(done_cyc - acc_cyc), 128'(7));
    check_writes(16'hFFFC, "wrap");
    chk("wrap idle after", 128'(busy), 128'(0));

    // Memory stall on blk1 for 3 cycles; irq edge mid-transfer.
    dev_interrupt = 1'b0;
    for (int i = 0; i < NB; i++) dev_mem[i] = rnd_block();
    start(16'h0100);
    chk("stall irq cleared", 128'(cpu_irq), 128'(0));
    dev_interrupt = 1'b1;
    tick();
    chk("irq edge during transfer", 128'(cpu_irq), 128'(1));
    repeat (3) tick();
    mem_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("stall hold%0d", k), 128'({mem_write, mem_addr, mem_data}), 128'({1'b1, 16'h0104, dev_mem[1]}));
      tick();
    end
    mem_ready = 1'b1;
    wait_done(50, "stall");
    chk("stall done cycle", 128'(done_cyc - acc_cyc), 128'(10));
    check_writes(16'h0100, "stall");

    // Grant loss for 2 cycles during WRITE blk1.
    for (int i = 0; i < NB; i++) dev_mem[i] = rnd_block();
    start(16'h0100);
    repeat (4) tick();
    chk("grant write blk1", 128'({mem_write, mem_addr}), 128'({1'b1, 16'h0104}));
    bg = 1'b0;
    tick();
    chk("grant lost req", 128'({mem_write, br, busy}), 128'(3'b011));
    tick();
    bg = 1'b1;
    tick();
    chk("grant refetch blk1", 128'({mem_write, dev_offset}), 128'({1'b0, 2'd1}));
    wait_done(50, "grant");
    chk("grant done cycle", 128'(done_cyc - acc_cyc), 128'(11));
    check_writes(16'h0100, "grant");
    repeat (2) tick();
    chk("grant done once", 128'(done_cnt), 128'(1));

    // Reset during FETCH blk2; command mid-transfer ignored.
    for (int i = 0; i < NB; i++) dev_mem[i] = rnd_block();
    b = WS'($urandom);
    start(b);
    tick();
    cmd_valid = 1'b1;
    cmd_addr  = ~b;
    tick();
    cmd_valid = 1'b0;
    repeat (3) tick();
    chk("rst fetch blk2", 128'({br, dev_offset}), 128'({1'b1, 2'd2}));
    reset = 1'b1;
    tick();
    chk("rst mid outputs", 128'({dev_offset, cpu_irq, br, mem_write, mem_addr, mem_data, busy, done}), 128'(0));
    reset = 1'b0;
    repeat (4) tick();
    chk("rst no done", 128'(done_cnt), 128'(0));
    chk("rst write count", 128'(wr_q.size()), 128'(2));
    if (wr_q.size() == 2) chk("rst base unchanged", 128'(wr_q[1]), 128'({b + WS'(BW), dev_mem[1]}));

    // Randomized grant and ready handshakes against the expected write list.
    for (int t = 0; t < 6; t++) begin
      int n;
      for (int i = 0; i < NB; i++) dev_mem[i] = rnd_block();
      b = WS'($urandom);
      bg = 1'b1; mem_ready = 1'b1;
      start(b);
      n = 0;
      while (done_cnt == 0 && n < 400) begin
        bg        = ($urandom_range(3) != 0);
        mem_ready = ($urandom_range(2) != 0);
        tick();
        n++;
      end
      chk($sformatf("rand%0d done seen", t), 128'(done_cnt != 0), 128'(1));
      check_writes(b, $sformatf("rand%0d", t));
      bg = 1'b1; mem_ready = 1'b1;
      repeat (2) tick();
      chk($sformatf("rand%0d done once", t), 128'({done_cnt, busy}), 128'({32'd1, 1'b0}));
    end

    chk("offset range", 128'(offset_bad), 128'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
